// File: rtl/dino_game_if.sv
// Signal bundle between the dino game sequencer and its surroundings.
// The master drives the frame/button/collision inputs; the slave is the sequencer.
interface dino_game_if;
  logic       frame_tick;
  logic       btn;
  logic       collide;
  logic [1:0] state;
  logic [7:0] dinoY;
  logic [8:0] cactusX;
  logic [8:0] x_dist;
  logic [7:0] cactusH1;
  logic [7:0] cactusH2;
  logic [7:0] score;

  modport master (
    output frame_tick, btn, collide,
    input  state, dinoY, cactusX, x_dist, cactusH1, cactusH2, score
  );

  modport slave (
    input  frame_tick, btn, collide,
    output state, dinoY, cactusX, x_dist, cactusH1, cactusH2, score
  );
endinterface

// File: rtl/dino_game_ctrl.sv
// Per-frame sequencer for the dino runner: jump physics, cactus scroll/respawn,
// scoring, collision end and win detection, advancing once per frame_tick.
//
// state | meaning
// IDLE  | waiting for a button press, play registers held at start values
// RUN   | game active, physics and scrolling advance on each frame_tick
// OVER  | collision seen, outputs frozen until a button press
// WIN   | score target reached, outputs frozen until a button press
module dino_game_ctrl #(
  parameter logic [7:0]        FLOOR_Y   = 8'd101,
  parameter logic signed [5:0] JUMP_V    = 6'sd12,
  parameter logic signed [5:0] GRAVITY   = 6'sd1,
  parameter logic [8:0]        SPEED     = 9'd4,
  parameter logic [8:0]        WRAP_X    = 9'd320,
  parameter logic [7:0]        MIN_H     = 8'd20,
  parameter logic [8:0]        MIN_DIST  = 9'd60,
  parameter logic [7:0]        WIN_SCORE = 8'd40
) (
  input logic        clk,
  input logic        rst,
  dino_game_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam logic [1:0] S_WIN  = 2'd3;

  logic [1:0]        state_q;
  logic [7:0]        dino_y;
  logic signed [5:0] vel;
  logic [8:0]        cactus_x;
  logic [8:0]        gap;
  logic [7:0]        height1;
  logic [7:0]        height2;
  logic [7:0]        score_q;
  logic              btn_q;
  logic              jump_pend;
  logic              hit;
  logic [7:0]        lfsr;

  logic              btn_rise;
  logic              grounded;
  logic              pend_eff;
  logic              game_done;
  logic              restart;
  logic [7:0]        lfsr_next;
  logic [4:0]        lfsr_mix;
  logic signed [9:0] y_sum;
  logic [9:0]        x_sum;

  assign btn_rise  = bus.btn & ~btn_q;
  assign grounded  = (dino_y == FLOOR_Y) && (vel == 6'sd0);
  // A press landing in the same cycle as the tick still counts for that tick.
  assign pend_eff  = jump_pend | (btn_rise & grounded);
  assign game_done = (state_q == S_OVER) || (state_q == S_WIN);
  assign restart   = (state_q == S_IDLE) || (game_done && btn_rise);
  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign lfsr_mix  = lfsr[4:0] ^ lfsr[7:3];
  assign y_sum     = $signed({2'b00, dino_y}) + $signed({{4{vel[5]}}, vel});
  assign x_sum     = {1'b0, cactus_x} + {1'b0, SPEED};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dino_y    <= FLOOR_Y;
      vel       <= 6'sd0;
      cactus_x  <= 9'd0;
      gap       <= MIN_DIST;
      height1   <= MIN_H;
      height2   <= MIN_H;
      score_q   <= 8'd0;
      btn_q     <= 1'b0;
      jump_pend <= 1'b0;
      hit       <= 1'b0;
      lfsr      <= 8'hA5;
    end else begin
      btn_q <= bus.btn;
      lfsr  <= lfsr_next;

      if (restart) begin
        dino_y    <= FLOOR_Y;
        vel       <= 6'sd0;
        cactus_x  <= 9'd0;
        score_q   <= 8'd0;
        hit       <= 1'b0;
        jump_pend <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (btn_rise) state_q <= S_RUN;
        end
        S_RUN: begin
          if (bus.frame_tick) begin
            hit <= 1'b0;
            if (hit || bus.collide) begin
              state_q <= S_OVER;
            end else if (score_q >= WIN_SCORE) begin
              state_q <= S_WIN;
            end else begin
              jump_pend <= 1'b0;
              if (pend_eff) begin
                vel    <= JUMP_V;
                dino_y <= dino_y + {2'b00, JUMP_V};
              end else if (!grounded) begin
                if (y_sum <= $signed({2'b00, FLOOR_Y})) begin
                  dino_y <= FLOOR_Y;
                  vel    <= 6'sd0;
                end else if (y_sum > 10'sd215) begin
                  dino_y <= 8'd215;
                  vel    <= 6'sd0 - GRAVITY;
                end else begin
                  dino_y <= y_sum[7:0];
                  vel    <= vel - GRAVITY;
                end
              end

              if (x_sum >= {1'b0, WRAP_X}) begin
                cactus_x <= 9'd0;
                height1  <= MIN_H + {3'b000, lfsr[4:0]};
                height2  <= MIN_H + {3'b000, lfsr_mix};
                gap      <= MIN_DIST + {2'b00, lfsr[7:5], 4'b0000};
                score_q  <= (score_q >= 8'd254) ? 8'd255 : score_q + 8'd2;
              end else begin
                cactus_x <= x_sum[8:0];
              end
            end
          end else begin
            if (bus.collide) hit <= 1'b1;
            jump_pend <= pend_eff;
          end
        end
        S_OVER, S_WIN: begin
          if (btn_rise) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.dinoY    = dino_y;
  assign bus.cactusX  = cactus_x;
  assign bus.x_dist   = gap;
  assign bus.cactusH1 = height1;
  assign bus.cactusH2 = height2;
  assign bus.score    = score_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl: directed scenarios plus randomized play
// compared against a frame-level behavioural model of the game rules.
module tb_dino_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  dino_game_if bus();

  dino_game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state (plain integers).
  int       m_state, m_y, m_vel, m_x, m_xd, m_h1, m_h2, m_score;
  bit       m_hit, m_pend, m_btn_q;
  bit [7:0] m_lfsr;

  logic [51:0] dut_vec;
  assign dut_vec = {bus.state, bus.dinoY, bus.cactusX, bus.x_dist,
                    bus.cactusH1, bus.cactusH2, bus.score};

  function automatic logic [51:0] exp_vec();
    return {2'(m_state), 8'(m_y), 9'(m_x), 9'(m_xd), 8'(m_h1), 8'(m_h2), 8'(m_score)};
  endfunction

  task automatic model_clear();
    m_y = 101; m_vel = 0; m_x = 0; m_score = 0; m_hit = 0; m_pend = 0;
  endtask

  task automatic model_reset();
    m_state = 0; model_clear();
    m_xd = 60; m_h1 = 20; m_h2 = 20; m_btn_q = 0; m_lfsr = 8'hA5;
  endtask

  // One clock of the game rules, evaluated from pre-edge values.
  task automatic model_clock(input bit b, input bit t, input bit c);
    bit rise, grounded, pend;
    int nxt, lo5, hi5;
    rise     = b && !m_btn_q;
    grounded = (m_y == 101) && (m_vel == 0);
    pend     = m_pend || (rise && grounded);
    case (m_state)
      0: begin
        model_clear();
        if (rise) m_state = 1;
      end
      1: begin
        if (t) begin
          if (m_hit || c) m_state = 2;
          else if (m_score >= 40) m_state = 3;
          else begin
            if (pend) begin
              m_vel = 12; m_y = m_y + 12;
            end else if (!grounded) begin
              nxt = m_y + m_vel;
              if (nxt <= 101) begin m_y = 101; m_vel = 0; end
              else if (nxt > 215) begin m_y = 215; m_vel = -1; end
              else begin m_y = nxt; m_vel = m_vel - 1; end
            end
            m_pend = 0;
            if (m_x + 4 >= 320) begin
              lo5     = int'(m_lfsr) % 32;
              hi5     = int'(m_lfsr) / 8;
              m_x     = 0;
              m_h1    = 20 + lo5;
              m_h2    = 20 + (lo5 ^ hi5);
              m_xd    = 60 + (int'(m_lfsr) / 32) * 16;
              m_score = (m_score + 2 > 255) ? 255 : m_score + 2;
            end else begin
              m_x = m_x + 4;
            end
          end
          m_hit = 0;
        end else begin
          if (c) m_hit = 1;
          m_pend = pend;
        end
      end
      default: begin
        if (rise) begin m_state = 0; model_clear(); end
      end
    endcase
    m_btn_q = b;
    m_lfsr  = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge.
  task automatic step(input bit b, input bit t, input bit c);
    bus.btn = b; bus.frame_tick = t; bus.collide = c;
    @(posedge clk);
    model_clock(b, t, c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.btn = 0; bus.frame_tick = 0; bus.collide = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    vectors++;
    if (dut_vec !== {2'd0, 8'd101, 9'd0, 9'd60, 8'd20, 8'd20, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", dut_vec,
               {2'd0, 8'd101, 9'd0, 9'd60, 8'd20, 8'd20, 8'd0});
    end
    rst = 1'b0;
    step(0, 1, 0);
    vectors++;
    if (bus.state !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_ignores_tick: got state %0d expected 0", bus.state);
    end
  endtask

  task automatic test_start();
    step(0, 0, 0);
    step(1, 0, 0);
    vectors++;
    if (bus.state !== 2'd1) begin
      miscompares++;
      $display("FAIL start_run: got state %0d expected 1", bus.state);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    vectors++;
    if (bus.cactusX !== 9'd40 || bus.dinoY !== 8'd101) begin
      miscompares++;
      $display("FAIL scroll_10_ticks: got x=%0d y=%0d expected x=40 y=101", bus.cactusX, bus.dinoY);
    end
  endtask

  task automatic test_jump();
    int traj[27] = '{113, 125, 136, 146, 155, 163, 170, 176, 181, 185, 188, 190, 191, 191,
                     190, 188, 185, 181, 176, 170, 163, 155, 146, 136, 125, 113, 101};
    bit b;
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 27; i++) begin
      b = (i % 2) == 1;  // repeated presses while airborne must not re-launch
      step(b, 0, 0);
      step(b, 1, 0);
      vectors++;
      if (bus.dinoY !== 8'(traj[i]) || dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL jump_frame_%0d: got y=%0d vec=%h expected y=%0d vec=%h",
                 i, bus.dinoY, dut_vec, traj[i], exp_vec());
      end
    end
    step(0, 1, 0);
    vectors++;
    if (bus.dinoY !== 8'd101) begin
      miscompares++;
      $display("FAIL landed_rest: got y=%0d expected 101", bus.dinoY);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int old_score;
    logic [7:0] l;
    logic [4:0] mix;
    while (m_x != 316 && n < 200) begin
      step(0, 1, 0);
      step(0, 0, 0);
      n++;
    end
    vectors++;
    if (bus.cactusX !== 9'd316) begin
      miscompares++;
      $display("FAIL reach_316: got x=%0d expected 316 after %0d ticks", bus.cactusX, n);
    end
    old_score = m_score;
    step(0, 1, 0);
    vectors++;
    if (bus.cactusX !== 9'd0 || bus.score !== 8'(old_score + 2)) begin
      miscompares++;
      $display("FAIL wrap_respawn: got x=%0d score=%0d expected x=0 score=%0d",
               bus.cactusX, bus.score, old_score + 2);
    end
    vectors++;
    if (bus.cactusH1 < 20 || bus.cactusH1 > 51 || bus.cactusH2 < 20 || bus.cactusH2 > 51 ||
        bus.x_dist < 60 || bus.x_dist > 172) begin
      miscompares++;
      $display("FAIL wrap_ranges: got h1=%0d h2=%0d gap=%0d expected 20..51/20..51/60..172",
               bus.cactusH1, bus.cactusH2, bus.x_dist);
    end
    // The LFSR byte is recoverable from H1 and the gap, so H2 must follow from them.
    l   = {3'(9'(bus.x_dist - 9'd60) >> 4), 5'(bus.cactusH1 - 8'd20)};
    mix = l[4:0] ^ l[7:3];
    vectors++;
    if (bus.cactusH2 !== 8'd20 + {3'b000, mix}) begin
      miscompares++;
      $display("FAIL wrap_h2_mix: got h2=%0d expected %0d", bus.cactusH2, 20 + mix);
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL wrap_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_collide();
    logic [51:0] frozen;
    step(0, 0, 1);
    step(0, 0, 0);
    vectors++;
    if (bus.state !== 2'd1) begin
      miscompares++;
      $display("FAIL collide_waits_tick: got state %0d expected 1", bus.state);
    end
    step(0, 1, 0);
    vectors++;
    if (bus.state !== 2'd2) begin
      miscompares++;
      $display("FAIL collide_over: got state %0d expected 2", bus.state);
    end
    frozen = exp_vec();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1'($urandom_range(0, 1)));
      vectors++;
      if (dut_vec !== frozen) begin
        miscompares++;
        $display("FAIL over_frozen_%0d: got %h expected %h", i, dut_vec, frozen);
      end
    end
    step(1, 0, 0);
    vectors++;
    if (bus.state !== 2'd0 || dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL over_to_idle: got %h expected %h", dut_vec, exp_vec());
    end
    step(0, 0, 0);
  endtask

  // Random presses and ticks (no collisions) until the model reaches the win score.
  task automatic run_random_to_win();
    int n = 0;
    bit b, t;
    b = 0;
    while (m_score < 40 && n < 8000) begin
      if ($urandom_range(0, 5) == 0) b = !b;
      t = 1'($urandom_range(0, 1));
      step(b, t, 0);
      n++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_play_%0d: got %h expected %h", n, dut_vec, exp_vec());
      end
    end
    vectors++;
    if (m_score < 40) begin
      miscompares++;
      $display("FAIL random_budget: got score %0d expected 40 within 8000 cycles", m_score);
    end
    step(0, 0, 0);
  endtask

  task automatic test_over_beats_win();
    step(1, 0, 0);
    run_random_to_win();
    step(0, 1, 1);
    vectors++;
    if (bus.state !== 2'd2) begin
      miscompares++;
      $display("FAIL over_beats_win: got state %0d expected 2", bus.state);
    end
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic test_win();
    step(1, 0, 0);
    vectors++;
    if (bus.state !== 2'd1 || bus.score !== 8'd0) begin
      miscompares++;
      $display("FAIL restart_run: got state %0d score %0d expected 1 0", bus.state, bus.score);
    end
    run_random_to_win();
    step(0, 1, 0);
    vectors++;
    if (bus.state !== 2'd3 || bus.score !== 8'd40) begin
      miscompares++;
      $display("FAIL win_state: got state %0d score %0d expected 3 40", bus.state, bus.score);
    end
    step(1, 0, 0);
    vectors++;
    if (bus.state !== 2'd0) begin
      miscompares++;
      $display("FAIL win_to_idle: got state %0d expected 0", bus.state);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    vectors++;
    if (bus.state !== 2'd1 || bus.score !== 8'd0) begin
      miscompares++;
      $display("FAIL win_restart: got state %0d score %0d expected 1 0", bus.state, bus.score);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.state !== 2'd0 || bus.dinoY !== 8'd101 || bus.cactusX !== 9'd0 || bus.score !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: got state=%0d y=%0d x=%0d score=%0d expected 0 101 0 0",
               bus.state, bus.dinoY, bus.cactusX, bus.score);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_jump();
    test_wrap();
    test_collide();
    test_over_beats_win();
    test_win();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
